// File: rtl/score_init_seq.sv
// Initialisation sequencer for the Needleman-Wunsch score RAM: writes the first
// row and first column with linear gap values 0, -GAP, ..., -N*GAP, then raises hit.
module score_init_seq #(
  parameter int N       = 8,
  parameter int SCORE_W = 8,
  parameter int GAP     = 2,
  parameter int ADDR_W  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_init,
  input  logic                      wr_ready,
  output logic                      we,
  output logic [ADDR_W-1:0]         addr,
  output logic signed [SCORE_W-1:0] data,
  output logic                      busy,
  output logic                      hit
);

  // Write handshake: a write transfers on a rising edge where we && wr_ready;
  // while wr_ready is low, we/addr/data are held unchanged until accepted.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int IDX_W = (N < 1) ? 1 : $clog2(N + 1);
  localparam logic [IDX_W-1:0]          IDX_LAST   = IDX_W'(N);
  localparam logic [IDX_W-1:0]          IDX_ONE    = IDX_W'(1);
  localparam logic [ADDR_W-1:0]         ROW_STRIDE = ADDR_W'(N + 1);
  localparam logic [ADDR_W-1:0]         ADDR_ONE   = ADDR_W'(1);
  localparam logic signed [SCORE_W-1:0] GAP_S      = SCORE_W'(GAP);

  state_t                      state_q, state_d;
  logic                        we_q, we_d;
  logic                        busy_q, busy_d;
  logic                        hit_q, hit_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic signed [SCORE_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        accept;

  assign accept = we_q && wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      hit_q   <= hit_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    busy_d  = busy_q;
    hit_d   = hit_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        hit_d = 1'b0;
        if (en_init) begin
          state_d = ROW;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          addr_d  = '0;
          data_d  = '0;
          idx_d   = '0;
        end
      end

      ROW: begin
        if (!en_init) begin
          state_d = IDLE;
          we_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (accept) begin
          if (idx_q == IDX_LAST) begin
            // Column starts at (1,0); (0,0) was already written by the row pass.
            state_d = COL;
            idx_d   = IDX_ONE;
            addr_d  = ROW_STRIDE;
            data_d  = -GAP_S;
          end else begin
            idx_d  = idx_q + IDX_ONE;
            addr_d = addr_q + ADDR_ONE;
            data_d = data_q - GAP_S;
          end
        end
      end

      COL: begin
        if (!en_init) begin
          state_d = IDLE;
          we_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (accept) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            hit_d   = 1'b1;
          end else begin
            idx_d  = idx_q + IDX_ONE;
            addr_d = addr_q + ROW_STRIDE;
            data_d = data_q - GAP_S;
          end
        end
      end

      DONE: begin
        // Re-arm only after en_init falls, so a held request never restarts.
        if (!en_init) begin
          state_d = IDLE;
          hit_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        hit_d   = 1'b0;
      end
    endcase
  end

  assign we   = we_q;
  assign addr = addr_q;
  assign data = data_q;
  assign busy = busy_q;
  assign hit  = hit_q;

endmodule

// File: tb/tb_score_init_seq.sv
// Bench for score_init_seq: N=4/GAP=2 instance for sweep, stall, abort, reset and
// re-arm scenarios, plus an N=1/GAP=3 corner instance.
module tb_score_init_seq;

  localparam int N  = 4;
  localparam int AW = 5;

  logic              clk;
  logic              rst;
  logic              en_init, wr_ready;
  logic              we, busy, hit;
  logic [AW-1:0]     addr;
  logic signed [7:0] data;

  logic              en1, rdy1;
  logic              we1, busy1, hit1;
  logic [1:0]        addr1;
  logic signed [7:0] data1;

  int errors = 0;
  int checks = 0;

  logic [AW+7:0] exp_q[$];
  logic [9:0]    exp1_q[$];

  score_init_seq #(.N(4), .SCORE_W(8), .GAP(2), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .en_init(en_init), .wr_ready(wr_ready),
    .we(we), .addr(addr), .data(data), .busy(busy), .hit(hit)
  );

  score_init_seq #(.N(1), .SCORE_W(8), .GAP(3), .ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .en_init(en1), .wr_ready(rdy1),
    .we(we1), .addr(addr1), .data(data1), .busy(busy1), .hit(hit1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW+7:0] pack(input int a, input int d);
    logic [31:0] av, dv;
    av = a;
    dv = d;
    return {av[AW-1:0], dv[7:0]};
  endfunction

  // Expected write stream for the N=4, GAP=2 instance.
  task automatic push_sweep();
    for (int i = 0; i <= N; i++) exp_q.push_back(pack(i, -2 * i));
    for (int i = 1; i <= N; i++) exp_q.push_back(pack(i * (N + 1), -2 * i));
  endtask

  // Drives one full sweep from the current negedge; stalls stall_n cycles on write stall_pos.
  task automatic do_sweep(input string name, input int stall_pos, input int stall_n);
    int k, stalled, hit_c;
    logic [AW+7:0] e;
    push_sweep();
    en_init  = 1'b1;
    wr_ready = 1'b1;
    k = 0;
    stalled = 0;
    hit_c = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (hit) begin
        hit_c = c;
        break;
      end
      if (we) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_with_we: got %b expected 1", name, busy);
        end
        e = (exp_q.size() > 0) ? exp_q[0] : '1;
        checks++;
        if ({addr, data} !== e) begin
          errors++;
          $display("FAIL %s write%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   name, k, addr, data, e[AW+7:8], $signed(e[7:0]));
        end
        if (k == stall_pos && stalled < stall_n) begin
          wr_ready = 1'b0;
          stalled++;
        end else begin
          wr_ready = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          k++;
        end
      end else begin
        checks++;
        errors++;
        $display("FAIL %s we_gap: got we=0 at cycle %0d expected 1", name, c);
      end
    end
    wr_ready = 1'b1;
    checks++;
    if (hit_c != 2 * N + 2 + stall_n) begin
      errors++;
      $display("FAIL %s hit_cycle: got %0d expected %0d", name, hit_c, 2 * N + 2 + stall_n);
    end
    checks++;
    if ({we, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s we_busy_at_hit: got %b expected 00", name, {we, busy});
    end
    checks++;
    if (exp_q.size() != 0 || k != 2 * N + 1) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, k, 2 * N + 1);
    end
    exp_q.delete();
  endtask

  task automatic drop_en();
    en_init = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_init = 1'b0; wr_ready = 1'b1;
    en1 = 1'b0; rdy1 = 1'b1;
    #3;
    checks++;
    if ({we, busy, hit, addr, data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {we, busy, hit, addr, data});
    end
    checks++;
    if ({we1, busy1, hit1, addr1, data1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_n1: got %h expected 0", {we1, busy1, hit1, addr1, data1});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({we, busy, hit} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 000", {we, busy, hit});
    end
  endtask

  task automatic test_sweep_and_done_hold();
    do_sweep("basic", -1, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({hit, we, busy} !== 3'b100) begin
        errors++;
        $display("FAIL done_hold%0d: got hit/we/busy=%b expected 100", c, {hit, we, busy});
      end
    end
    en_init = 1'b0;
    @(negedge clk);
    checks++;
    if ({hit, we} !== 2'b00) begin
      errors++;
      $display("FAIL hit_clear: got hit/we=%b expected 00", {hit, we});
    end
    @(negedge clk);
    do_sweep("second", -1, 0);
    drop_en();
  endtask

  task automatic test_stall();
    do_sweep("stall", 2, 3);
    drop_en();
  endtask

  task automatic test_abort();
    int found;
    en_init = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (we && addr == 5'd5) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found != 1 || data !== -8'sd2) begin
      errors++;
      $display("FAIL abort_reach: got found=%0d data=%0d expected 1 and -2", found, data);
    end
    en_init = 1'b0;
    @(negedge clk);
    checks++;
    if ({we, busy, hit} !== 3'b000) begin
      errors++;
      $display("FAIL abort_outputs: got we/busy/hit=%b expected 000", {we, busy, hit});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({we, hit} !== 2'b00) begin
        errors++;
        $display("FAIL abort_idle%0d: got we/hit=%b expected 00", c, {we, hit});
      end
    end
    do_sweep("restart", -1, 0);
    drop_en();
  endtask

  task automatic test_async_reset();
    int found;
    en_init = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (we && addr == 5'd10) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found != 1) begin
      errors++;
      $display("FAIL rst_reach_col: got %0d expected 1", found);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({we, busy, hit, addr, data} !== '0) begin
      errors++;
      $display("FAIL async_rst: got %h expected 0", {we, busy, hit, addr, data});
    end
    @(negedge clk);
    checks++;
    if ({we, busy, hit, addr, data} !== '0) begin
      errors++;
      $display("FAIL rst_held: got %h expected 0", {we, busy, hit, addr, data});
    end
    rst = 1'b0;
    do_sweep("post_rst", -1, 0);
    drop_en();
  endtask

  task automatic test_corner_n1();
    int k, hit_c;
    logic [9:0] e;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 0 : -3;
      exp1_q.push_back({2'(i), d[7:0]});
    end
    en1 = 1'b1;
    k = 0;
    hit_c = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (hit1) begin
        hit_c = c;
        break;
      end
      if (we1) begin
        e = (exp1_q.size() > 0) ? exp1_q.pop_front() : '1;
        checks++;
        if ({addr1, data1} !== e) begin
          errors++;
          $display("FAIL n1_write%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   k, addr1, data1, e[9:8], $signed(e[7:0]));
        end
        k++;
      end
    end
    checks++;
    if (hit_c != 4 || k != 3 || we1 !== 1'b0) begin
      errors++;
      $display("FAIL n1_hit: got hit_cycle=%0d writes=%0d we=%b expected 4 3 0", hit_c, k, we1);
    end
    en1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sweep_and_done_hold();
    test_stall();
    test_abort();
    test_async_reset();
    test_corner_n1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_init_seq.md
# score_init_seq

Parametrised initialisation sequencer for the Needleman-Wunsch score RAM. On `en_init` it writes the first row and first column of the (N+1)x(N+1) score matrix with the linear gap boundary values 0, -GAP, -2·GAP, …, -N·GAP, then raises `hit`. It generalises the fixed init counter with configurable size, width and penalty, a write-address/data stream, RAM back-pressure and abort handling. It sits between the top-level control FSM and the score RAM write port.

## Interface
- `N`, 8, sequence length; the matrix is (N+1)x(N+1); N ≥ 1.
- `SCORE_W`, 8, signed score width; requires N·GAP ≤ 2^(SCORE_W-1).
- `GAP`, 2, gap penalty magnitude (positive).
- `ADDR_W`, 7, RAM address width; requires (N+1)² ≤ 2^ADDR_W. Row-major layout, addr = row·(N+1) + col.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en_init` in 1: level request; high starts and sustains the sweep; low aborts it or re-arms the block.
- `wr_ready` in 1: RAM accepts a write this cycle.
- `we` out 1: write valid.
- `addr` out ADDR_W: write address.
- `data` out SCORE_W: signed write value.
- `busy` out 1: high in ROW or COL.
- `hit` out 1: sweep complete; held high in DONE.

## Operation
- Reset values: state IDLE; `we`, `busy` and `hit` = 0; `addr` and `data` = 0; index = 0.
- All outputs are registered.
- FSM states: IDLE, ROW, COL, DONE.
- IDLE -> ROW when `en_init` = 1. That edge loads `addr` = 0, `data` = 0, `we` = 1 and index i = 0.
- ROW: writes cell (0,i) with `addr` = i and `data` = -i·GAP, for i = 0..N.
- COL: writes cell (i,0) with `addr` = i·(N+1) and `data` = -i·GAP, for i = 1..N. Cell (0,0) is not rewritten.
- A write is accepted on an edge where `we` && `wr_ready`. Only accepted writes advance i, `addr` and `data`.
- While `wr_ready` = 0, `we`, `addr` and `data` hold stable.
- Arithmetic uses accumulators, with no multiplier:
  - `data` -= GAP per step.
  - Row `addr` += 1.
  - Column `addr` += N+1.
- Transitions:
  - ROW -> COL on acceptance of i = N. That edge loads `addr` = N+1, `data` = -GAP.
  - COL -> DONE on acceptance of i = N. That edge sets `we` = 0, `busy` = 0, `hit` = 1.
- DONE: `hit` stays 1 while `en_init` = 1. When `en_init` = 0, go to IDLE and `hit` = 0 next edge. A new sweep needs `en_init` to fall and then rise again.
- Abort: `en_init` = 0 in ROW or COL. Next edge goes to IDLE with `we` = 0 and `busy` = 0; `hit` is never asserted. An accepted write on that same edge still counts as written to the RAM.
- `rst` asserted at any time immediately forces the reset values, independent of `clk`.
- Total writes per sweep: 2N+1.

## Timing
- Start latency: `we` = 1 in the first cycle after the edge that samples `en_init` = 1.
- Throughput: 1 write per cycle when `wr_ready` = 1.
- With `wr_ready` tied high and start edge E0:
  - writes are presented in cycles E0+1 … E0+2N+1;
  - `hit` rises at E0+2N+1, the edge accepting the last write;
  - `hit` is visible during cycle E0+2N+2.
- Each cycle of `wr_ready` = 0 with `we` = 1 adds exactly one cycle to the sweep.
- `busy` = 1 exactly while `we` = 1 during a sweep.

## Test plan
- N=4, GAP=2, SCORE_W=8, ADDR_W=5, `wr_ready` = 1, `en_init` raised after reset -> write pairs (addr,data):
  - row: (0,0)(1,-2)(2,-4)(3,-6)(4,-8);
  - column: (5,-2)(10,-4)(15,-6)(20,-8);
  - `hit` = 1 nine cycles after the first write; `we` = 0 thereafter.
- Same setup, `wr_ready` held low for 3 cycles at the (2,-4) write -> that write is held unchanged for 3 extra cycles; the sequence is otherwise identical; `hit` is delayed by 3 cycles.
- `en_init` dropped while presenting (5,-2) -> next cycle `we` = 0, `busy` = 0, state IDLE, `hit` never rises. Re-raising `en_init` restarts from (0,0).
- `rst` pulsed asynchronously mid-COL (between clock edges) -> all outputs read 0 immediately. After release with `en_init` = 1, a full sweep restarts from (0,0).
- After DONE, hold `en_init` high for 5 cycles -> `hit` stays 1 with no writes. Drop then raise `en_init` -> `hit` clears and a second identical sweep occurs.
- Corner N=1, GAP=3 -> writes (0,0)(1,-3)(2,-3), then `hit`.
